// File: rtl/csm_pkg.sv
// Shared types and defaults for the dual-port shared memory with a lock.
package csm_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_LOCKED   = 2'b01,
    ERR_BADREL   = 2'b10,
    ERR_CONFLICT = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    FREE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WDATA = 2'b01,
    RESP  = 2'b10
  } port_state_t;

  // Request decoded by a port in IDLE, judged by the top in the same cycle.
  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_READ    = 3'd1,
    REQ_WRITE   = 3'd2,
    REQ_HOLD    = 3'd3,
    REQ_REL     = 3'd4,
    REQ_ILLEGAL = 3'd5
  } req_t;

endpackage

// File: rtl/csm_port_fsm.sv
// One access port: decodes enable/hold/release in IDLE, sequences the write
// data phase and registers the ack/err/out_data responses.
module csm_port_fsm
  import csm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_in_AD,
  input  logic              i_rw,
  input  logic              i_enable,
  input  logic              i_hold,
  input  logic              i_release,
  input  err_t              i_result,
  input  logic [DATA_W-1:0] i_rdata,
  output req_t              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_ack,
  output logic [1:0]        o_err
);

  port_state_t       r_state;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_ack;
  err_t              r_err;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    o_req = REQ_NONE;
    if (r_state == IDLE) begin
      case ({i_enable, i_hold, i_release})
        3'b000:  o_req = REQ_NONE;
        3'b100:  o_req = i_rw ? REQ_READ : REQ_WRITE;
        3'b010:  o_req = REQ_HOLD;
        3'b001:  o_req = REQ_REL;
        default: o_req = REQ_ILLEGAL;
      endcase
    end
  end

  assign o_addr     = i_in_AD[ADDR_W-1:0];
  assign o_wr_en    = (r_state == WDATA);
  assign o_wr_addr  = r_waddr;
  assign o_wr_data  = i_in_AD;
  assign o_out_data = r_out_data;
  assign o_ack      = r_ack;
  assign o_err      = r_err;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state    <= IDLE;
      r_waddr    <= '0;
      r_out_data <= '0;
      r_ack      <= 1'b0;
      r_err      <= ERR_OK;
    end else begin
      r_ack <= 1'b0;
      r_err <= ERR_OK;
      case (r_state)
        IDLE: begin
          if (o_req != REQ_NONE) begin
            if (i_result != ERR_OK) begin
              r_err <= i_result;
            end else begin
              case (o_req)
                REQ_READ: begin
                  r_out_data <= i_rdata;
                  r_ack      <= 1'b1;
                  r_state    <= RESP;
                end
                REQ_WRITE: begin
                  r_waddr <= o_addr;
                  r_state <= WDATA;
                end
                REQ_HOLD, REQ_REL: begin
                  r_ack   <= 1'b1;
                  r_state <= RESP;
                end
                default: ;
              endcase
            end
          end
        end
        WDATA: begin
          r_ack   <= 1'b1;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/csm_shared_mem.sv
// Dual-port 2**ADDR_W x DATA_W shared memory with an exclusive lock and
// A-priority arbitration of simultaneous requests.
module csm_shared_mem
  import csm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_in_AD,
  input  logic              A_rw,
  input  logic              A_enable,
  input  logic              A_hold,
  input  logic              A_release,
  output logic [DATA_W-1:0] A_out_data,
  output logic              A_ack,
  output logic [1:0]        A_err,
  input  logic [DATA_W-1:0] B_in_AD,
  input  logic              B_rw,
  input  logic              B_enable,
  input  logic              B_hold,
  input  logic              B_release,
  output logic [DATA_W-1:0] B_out_data,
  output logic              B_ack,
  output logic [1:0]        B_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  owner_t            r_owner;

  req_t              w_req_a, w_req_b;
  err_t              w_res_a, w_res_b;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b;
  logic              w_wr_en_a, w_wr_en_b;
  logic [ADDR_W-1:0] w_wr_addr_a, w_wr_addr_b;
  logic [DATA_W-1:0] w_wr_data_a, w_wr_data_b;
  logic [DATA_W-1:0] w_rdata_a, w_rdata_b;
  logic              w_a_wr_ok, w_a_take, w_a_free, w_b_take, w_b_free;

  csm_port_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_AD    (A_in_AD),
    .i_rw       (A_rw),
    .i_enable   (A_enable),
    .i_hold     (A_hold),
    .i_release  (A_release),
    .i_result   (w_res_a),
    .i_rdata    (w_rdata_a),
    .o_req      (w_req_a),
    .o_addr     (w_addr_a),
    .o_wr_en    (w_wr_en_a),
    .o_wr_addr  (w_wr_addr_a),
    .o_wr_data  (w_wr_data_a),
    .o_out_data (A_out_data),
    .o_ack      (A_ack),
    .o_err      (A_err)
  );

  csm_port_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_AD    (B_in_AD),
    .i_rw       (B_rw),
    .i_enable   (B_enable),
    .i_hold     (B_hold),
    .i_release  (B_release),
    .i_result   (w_res_b),
    .i_rdata    (w_rdata_b),
    .o_req      (w_req_b),
    .o_addr     (w_addr_b),
    .o_wr_en    (w_wr_en_b),
    .o_wr_addr  (w_wr_addr_b),
    .o_wr_data  (w_wr_data_b),
    .o_out_data (B_out_data),
    .o_ack      (B_ack),
    .o_err      (B_err)
  );

  assign w_rdata_a = r_mem[w_addr_a];
  assign w_rdata_b = r_mem[w_addr_b];

  // Port A is judged first; port B only loses a tie against an accepted A request.
  always_comb begin
    w_res_a = ERR_OK;
    case (w_req_a)
      REQ_ILLEGAL:                  w_res_a = ERR_CONFLICT;
      REQ_READ, REQ_WRITE, REQ_HOLD: if (r_owner == OWN_B) w_res_a = ERR_LOCKED;
      REQ_REL:                      if (r_owner != OWN_A) w_res_a = ERR_BADREL;
      default: ;
    endcase
  end

  assign w_a_wr_ok = (w_req_a == REQ_WRITE) && (w_res_a == ERR_OK);
  assign w_a_take  = (w_req_a == REQ_HOLD) && (w_res_a == ERR_OK) && (r_owner == FREE);
  assign w_a_free  = (w_req_a == REQ_REL) && (w_res_a == ERR_OK);

  always_comb begin
    w_res_b = ERR_OK;
    case (w_req_b)
      REQ_ILLEGAL: w_res_b = ERR_CONFLICT;
      REQ_READ:    if (r_owner == OWN_A) w_res_b = ERR_LOCKED;
      REQ_WRITE: begin
        if (r_owner == OWN_A)                          w_res_b = ERR_LOCKED;
        else if (w_a_wr_ok && (w_addr_a == w_addr_b))  w_res_b = ERR_CONFLICT;
      end
      REQ_HOLD: begin
        if (r_owner == OWN_A) w_res_b = ERR_LOCKED;
        else if (w_a_take)    w_res_b = ERR_CONFLICT;
      end
      REQ_REL:     if (r_owner != OWN_B) w_res_b = ERR_BADREL;
      default: ;
    endcase
  end

  assign w_b_take = (w_req_b == REQ_HOLD) && (w_res_b == ERR_OK) && (r_owner == FREE);
  assign w_b_free = (w_req_b == REQ_REL) && (w_res_b == ERR_OK);

  always_ff @(posedge clk) begin
    if (reset_n)       r_owner <= FREE;
    else if (w_a_take) r_owner <= OWN_A;
    else if (w_a_free) r_owner <= FREE;
    else if (w_b_take) r_owner <= OWN_B;
    else if (w_b_free) r_owner <= FREE;
  end

  // NOTE: clearing the whole array in one reset edge forces a flop array;
  // a RAM macro cannot be reset like this. Reset also wins over a pending write.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_mem <= '{default: '0};
    end else begin
      if (w_wr_en_b) r_mem[w_wr_addr_b] <= w_wr_data_b;
      if (w_wr_en_a) r_mem[w_wr_addr_a] <= w_wr_data_a;
    end
  end

endmodule

// File: tb/tb_csm_shared_mem.sv
// Directed bench for csm_shared_mem: stimulus pushes expected responses per port,
// a negedge monitor pops and compares whenever ack or err appears.
module tb_csm_shared_mem;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] A_in_AD, B_in_AD;
  logic       A_rw, A_enable, A_hold, A_release;
  logic       B_rw, B_enable, B_hold, B_release;
  logic [7:0] A_out_data, B_out_data;
  logic       A_ack, B_ack;
  logic [1:0] A_err, B_err;

  csm_shared_mem dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .A_in_AD    (A_in_AD),
    .A_rw       (A_rw),
    .A_enable   (A_enable),
    .A_hold     (A_hold),
    .A_release  (A_release),
    .A_out_data (A_out_data),
    .A_ack      (A_ack),
    .A_err      (A_err),
    .B_in_AD    (B_in_AD),
    .B_rw       (B_rw),
    .B_enable   (B_enable),
    .B_hold     (B_hold),
    .B_release  (B_release),
    .B_out_data (B_out_data),
    .B_ack      (B_ack),
    .B_err      (B_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic       ack;
    logic [1:0] err;
    logic       chk;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic expect_rsp(input bit pb, input int dly, input logic ack, input logic [1:0] err,
                            input logic chk, input logic [7:0] data, input string name);
    exp_t e;
    e.name = name; e.cyc = cyc + dly; e.ack = ack; e.err = err; e.chk = chk; e.data = data;
    if (pb) qb.push_back(e);
    else    qa.push_back(e);
  endtask

  task automatic monitor_port(input bit pb, input logic ack, input logic [1:0] err,
                              input logic [7:0] data);
    exp_t e;
    if ((pb && qb.size() == 0) || (!pb && qa.size() == 0)) begin
      n_total++;
      $display("FAIL %s_unexpected: ack=%0b err=%0d at cycle %0d, nothing expected",
               pb ? "B" : "A", ack, err, cyc);
    end else begin
      if (pb) e = qb.pop_front();
      else    e = qa.pop_front();
      check({e.name, "_cycle"}, cyc, e.cyc);
      check({e.name, "_ack"}, int'(ack), int'(e.ack));
      check({e.name, "_err"}, int'(err), int'(e.err));
      if (e.chk) check({e.name, "_data"}, int'(data), int'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (A_ack || A_err != 2'b00) monitor_port(1'b0, A_ack, A_err, A_out_data);
    if (B_ack || B_err != 2'b00) monitor_port(1'b1, B_ack, B_err, B_out_data);
  end

  task automatic clr();
    A_enable = 0; A_rw = 0; A_hold = 0; A_release = 0; A_in_AD = 8'h00;
    B_enable = 0; B_rw = 0; B_hold = 0; B_release = 0; B_in_AD = 8'h00;
  endtask

  task automatic req(input bit pb, input logic en, input logic rw, input logic hold,
                     input logic rel, input logic [7:0] ad);
    if (pb) begin B_enable = en; B_rw = rw; B_hold = hold; B_release = rel; B_in_AD = ad; end
    else    begin A_enable = en; A_rw = rw; A_hold = hold; A_release = rel; A_in_AD = ad; end
  endtask

  task automatic finish_op();
    @(negedge clk); clr();
    @(negedge clk);
  endtask

  task automatic rd(input bit pb, input logic [7:0] addr, input logic [1:0] err,
                    input logic [7:0] data, input string name);
    req(pb, 1, 1, 0, 0, addr);
    if (err == 2'b00) expect_rsp(pb, 1, 1'b1, 2'b00, 1'b1, data, name);
    else              expect_rsp(pb, 1, 1'b0, err, 1'b0, 8'h00, name);
    finish_op();
  endtask

  task automatic lk(input bit pb, input bit is_rel, input logic [1:0] err, input string name);
    req(pb, 0, 0, !is_rel, is_rel, 8'h00);
    if (err == 2'b00) expect_rsp(pb, 1, 1'b1, 2'b00, 1'b0, 8'h00, name);
    else              expect_rsp(pb, 1, 1'b0, err, 1'b0, 8'h00, name);
    finish_op();
  endtask

  task automatic wr(input bit pb, input logic [7:0] addr, input logic [7:0] data, input string name);
    req(pb, 1, 0, 0, 0, addr);
    expect_rsp(pb, 2, 1'b1, 2'b00, 1'b0, 8'h00, name);
    @(negedge clk);
    req(pb, 0, 0, 0, 0, data);
    finish_op();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_A_out_data", int'(A_out_data), 0);
    check("rst_A_ack", int'(A_ack), 0);
    check("rst_A_err", int'(A_err), 0);
    check("rst_B_out_data", int'(B_out_data), 0);
    check("rst_B_ack", int'(B_ack), 0);
    check("rst_B_err", int'(B_err), 0);
    reset_n = 1'b0;
    @(negedge clk);

    // Basic write then read on A.
    wr(0, 8'h10, 8'h3C, "A_wr_10");
    rd(0, 8'h10, 2'b00, 8'h3C, "A_rd_10");

    // Lock by A blocks B; out_data holds across the lock ack.
    req(0, 0, 0, 1, 0, 8'h00);
    expect_rsp(0, 1, 1'b1, 2'b00, 1'b1, 8'h3C, "A_hold1");
    finish_op();
    rd(1, 8'h10, 2'b01, 8'h00, "B_rd_locked");
    lk(0, 1, 2'b00, "A_rel1");
    rd(1, 8'h10, 2'b00, 8'h3C, "B_rd_10");

    // Bad releases.
    lk(0, 0, 2'b00, "A_hold2");
    lk(1, 1, 2'b10, "B_rel_nonowner");
    lk(0, 1, 2'b00, "A_rel2");
    lk(0, 1, 2'b10, "A_rel_free");

    // Simultaneous hold: A wins.
    req(0, 0, 0, 1, 0, 8'h00);
    req(1, 0, 0, 1, 0, 8'h00);
    expect_rsp(0, 1, 1'b1, 2'b00, 1'b0, 8'h00, "A_hold_tie");
    expect_rsp(1, 1, 1'b0, 2'b11, 1'b0, 8'h00, "B_hold_tie");
    finish_op();
    rd(1, 8'h10, 2'b01, 8'h00, "B_rd_owner_A");
    lk(0, 1, 2'b00, "A_rel3");

    // Simultaneous writes to one address: A lands, B rejected.
    req(0, 1, 0, 0, 0, 8'h20);
    req(1, 1, 0, 0, 0, 8'h20);
    expect_rsp(0, 2, 1'b1, 2'b00, 1'b0, 8'h00, "A_wr_20_tie");
    expect_rsp(1, 1, 1'b0, 2'b11, 1'b0, 8'h00, "B_wr_20_tie");
    @(negedge clk);
    req(0, 0, 0, 0, 0, 8'h55);
    req(1, 0, 0, 0, 0, 8'hAA);
    finish_op();
    req(0, 1, 1, 0, 0, 8'h20);
    req(1, 1, 1, 0, 0, 8'h20);
    expect_rsp(0, 1, 1'b1, 2'b00, 1'b1, 8'h55, "A_rd_20");
    expect_rsp(1, 1, 1'b1, 2'b00, 1'b1, 8'h55, "B_rd_20");
    finish_op();

    // Read in the same cycle as a write's address phase returns old data.
    req(0, 1, 0, 0, 0, 8'h40);
    req(1, 1, 1, 0, 0, 8'h40);
    expect_rsp(0, 2, 1'b1, 2'b00, 1'b0, 8'h00, "A_wr_40a");
    expect_rsp(1, 1, 1'b1, 2'b00, 1'b1, 8'h00, "B_rd_40_addr");
    @(negedge clk);
    req(0, 0, 0, 0, 0, 8'h66);
    req(1, 0, 0, 0, 0, 8'h00);
    finish_op();
    // Read during the write's data cycle also returns old data.
    req(0, 1, 0, 0, 0, 8'h40);
    expect_rsp(0, 2, 1'b1, 2'b00, 1'b0, 8'h00, "A_wr_40b");
    @(negedge clk);
    req(0, 0, 0, 0, 0, 8'h99);
    req(1, 1, 1, 0, 0, 8'h40);
    expect_rsp(1, 1, 1'b1, 2'b00, 1'b1, 8'h66, "B_rd_40_data");
    finish_op();
    rd(1, 8'h40, 2'b00, 8'h99, "B_rd_40_new");

    // Illegal combination: no action, lock stays free for B.
    req(0, 1, 1, 1, 0, 8'h10);
    expect_rsp(0, 1, 1'b0, 2'b11, 1'b0, 8'h00, "A_illegal");
    finish_op();
    lk(1, 0, 2'b00, "B_hold");
    lk(1, 1, 2'b00, "B_rel");

    // Reset during the data cycle of a locked write aborts it and frees the lock.
    lk(0, 0, 2'b00, "A_hold4");
    req(0, 1, 0, 0, 0, 8'h30);
    @(negedge clk);
    req(0, 0, 0, 0, 0, 8'h77);
    reset_n = 1'b1;
    @(negedge clk);
    clr();
    check("mid_rst_A_ack", int'(A_ack), 0);
    check("mid_rst_A_out_data", int'(A_out_data), 0);
    reset_n = 1'b0;
    @(negedge clk);
    rd(1, 8'h30, 2'b00, 8'h00, "B_rd_30_after_rst");
    rd(0, 8'h10, 2'b00, 8'h00, "A_rd_10_cleared");

    repeat (3) @(negedge clk);
    check("A_pending_left", qa.size(), 0);
    check("B_pending_left", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
